// File: rtl/ysyx_23060208_ifu_prefetch_pkg.sv
// Shared constants for the prefetching instruction fetch unit.
package ysyx_23060208_ifu_prefetch_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam axi_resp_e   AXI_RESP_OKAY    = RESP_OKAY;
    localparam int          NPC_DATA_WIDTH   = 32;

    // IFU->IDU payload is {pc, inst, fault}.
    function automatic int ifu_to_idu_bus_w(input int dw);
        return 2 * dw + 1;
    endfunction

    localparam int IFU_TO_IDU_BUS = ifu_to_idu_bus_w(NPC_DATA_WIDTH);

endpackage

// File: rtl/ysyx_23060208_ifu_prefetch_sync_fifo.sv
// Small synchronous FIFO with flush; head is visible on dout while not empty.
module ysyx_23060208_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so push on full+pop is legal.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ysyx_23060208_ifu_prefetch.sv
// Pipelined instruction prefetcher: multiple AXI4-Lite reads in flight,
// returned instructions queued for IDU, redirects squash stale responses.
module ysyx_23060208_ifu_prefetch
    import ysyx_23060208_ifu_prefetch_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC        = DATA_WIDTH'(RESET_PC_DEFAULT),
    parameter int                    FETCH_DEPTH     = 4,
    parameter int                    MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  ifu_to_idu_valid,
    input  logic                  ifu_to_idu_ready,
    output logic [DATA_WIDTH-1:0] ifu_to_idu_pc,
    output logic [DATA_WIDTH-1:0] ifu_to_idu_inst,
    output logic                  ifu_to_idu_fault,
    output logic [DATA_WIDTH-1:0] isram_araddr,
    output logic                  isram_arvalid,
    input  logic                  isram_arready,
    input  logic [DATA_WIDTH-1:0] isram_rdata,
    input  logic [1:0]            isram_rresp,
    input  logic                  isram_rvalid,
    output logic                  isram_rready
);

    localparam int BUS_W = ifu_to_idu_bus_w(DATA_WIDTH);
    localparam int OW    = $clog2(MAX_OUTSTANDING) + 1;
    localparam int IW    = $clog2(FETCH_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] fetch_pc;
    logic [DATA_WIDTH-1:0] fetch_pc_next;
    logic [DATA_WIDTH-1:0] araddr_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic                  ar_stale;    // pending AR was overtaken by a redirect
    logic [OW-1:0]         drop_cnt;

    logic                  ar_hs;
    logic                  r_hs;
    logic                  resp_fault;
    logic                  can_issue;
    logic [OW-1:0]         ost_after;
    logic [31:0]           occupancy;

    logic [DATA_WIDTH-1:0] tq_dout;
    logic [OW-1:0]         tq_count;
    logic                  tq_full;
    logic                  tq_empty;

    logic                  iq_push;
    logic                  iq_pop;
    logic [BUS_W-1:0]      iq_din;
    logic [BUS_W-1:0]      iq_dout;
    logic [IW-1:0]         iq_count;
    logic                  iq_full;
    logic                  iq_empty;

    assign isram_arvalid = arvalid_q;
    assign isram_araddr  = araddr_q;
    assign isram_rready  = rready_q;

    assign ar_hs      = arvalid_q && isram_arready;
    // Responses without a matching tag are ignored rather than corrupting state.
    assign r_hs       = isram_rvalid && rready_q && !tq_empty;
    assign resp_fault = (isram_rresp != AXI_RESP_OKAY);

    assign iq_push = r_hs && (drop_cnt == '0) && !redirect_valid;
    assign iq_din  = {tq_dout, (resp_fault ? '0 : isram_rdata), resp_fault};

    assign ifu_to_idu_valid = !iq_empty && !redirect_valid;
    assign iq_pop           = ifu_to_idu_valid && ifu_to_idu_ready;
    assign {ifu_to_idu_pc, ifu_to_idu_inst, ifu_to_idu_fault} = iq_empty ? '0 : iq_dout;

    // In-flight count after this cycle's AR/R handshakes.
    assign ost_after = tq_count + OW'(ar_hs) - OW'(r_hs);
    // Queue slots already spoken for: buffered + in flight + accepted now.
    // A same-cycle pop is ignored, which only delays the next issue.
    assign occupancy = 32'(iq_count) + 32'(tq_count) + 32'(ar_hs);

    // Next fetch address: redirect wins, stale ARs do not advance the PC.
    always_comb begin
        fetch_pc_next = fetch_pc;
        if (redirect_valid)
            fetch_pc_next = redirect_pc;
        else if (ar_hs && !ar_stale)
            fetch_pc_next = fetch_pc + DATA_WIDTH'(4);
    end

    // Issue when the AR slot is free (or frees this cycle) and space is reserved.
    always_comb begin
        can_issue = !redirect_valid
                 && (!arvalid_q || ar_hs)
                 && (!tq_full || r_hs)
                 && (ost_after < OW'(MAX_OUTSTANDING))
                 && (occupancy < 32'(FETCH_DEPTH))
                 && !iq_full;
    end

    // AR channel, fetch PC and stale-response bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc  <= RESET_PC;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ar_stale  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            rready_q <= 1'b1;
            fetch_pc <= fetch_pc_next;
            if (can_issue) begin
                arvalid_q <= 1'b1;
                araddr_q  <= fetch_pc_next;
            end else if (ar_hs) begin
                arvalid_q <= 1'b0;
            end
            if (redirect_valid && arvalid_q && !ar_hs)
                ar_stale <= 1'b1;
            else if (ar_hs)
                ar_stale <= 1'b0;
            if (redirect_valid)
                drop_cnt <= ost_after;
            else
                drop_cnt <= drop_cnt - OW'(r_hs && (drop_cnt != '0))
                                     + OW'(ar_hs && ar_stale);
        end
    end

    // PCs of accepted ARs, consumed in order by responses.
    ysyx_23060208_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .push  (ar_hs),
        .din   (araddr_q),
        .pop   (r_hs),
        .flush (1'b0),
        .dout  (tq_dout),
        .count (tq_count),
        .full  (tq_full),
        .empty (tq_empty)
    );

    // Fetched instructions waiting for IDU.
    ysyx_23060208_sync_fifo #(
        .WIDTH (BUS_W),
        .DEPTH (FETCH_DEPTH)
    ) u_inst_q (
        .clk   (clk),
        .rst   (rst),
        .push  (iq_push),
        .din   (iq_din),
        .pop   (iq_pop),
        .flush (redirect_valid),
        .dout  (iq_dout),
        .count (iq_count),
        .full  (iq_full),
        .empty (iq_empty)
    );

endmodule

// File: tb/tb_ysyx_23060208_ifu_prefetch.sv
// Self-checking bench: AXI-Lite slave model, scoreboard of expected IDU words.
module tb_ysyx_23060208_ifu_prefetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] RD_PC  = 32'h8000_0100;

    typedef struct { logic [31:0] addr; bit stale; } rq_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; logic fault; } exp_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; logic fault; int cyc; } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ifu_to_idu_valid;
    logic        ifu_to_idu_ready = 1'b0;
    logic [31:0] ifu_to_idu_pc;
    logic [31:0] ifu_to_idu_inst;
    logic        ifu_to_idu_fault;
    logic [31:0] isram_araddr;
    logic        isram_arvalid;
    logic        isram_arready = 1'b0;
    logic [31:0] isram_rdata = '0;
    logic [1:0]  isram_rresp = '0;
    logic        isram_rvalid = 1'b0;
    logic        isram_rready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // stimulus knobs
    bit          idu_ready = 1'b0;
    bit          resp_hold = 1'b0;
    bit          ar_block  = 1'b0;
    bit          redir_req = 1'b0;
    logic [31:0] redir_target = '0;
    logic [31:0] err_addr = '0;

    // model state
    rq_t         rq[$];
    exp_t        sb[$];
    obs_t        idu_log[$];
    logic [31:0] ar_log[$];
    bit          pend_stale = 1'b0;
    bit          ar_wait = 1'b0;
    logic [31:0] ar_held = '0;

    ysyx_23060208_ifu_prefetch dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .ifu_to_idu_valid (ifu_to_idu_valid),
        .ifu_to_idu_ready (ifu_to_idu_ready),
        .ifu_to_idu_pc    (ifu_to_idu_pc),
        .ifu_to_idu_inst  (ifu_to_idu_inst),
        .ifu_to_idu_fault (ifu_to_idu_fault),
        .isram_araddr     (isram_araddr),
        .isram_arvalid    (isram_arvalid),
        .isram_arready    (isram_arready),
        .isram_rdata      (isram_rdata),
        .isram_rresp      (isram_rresp),
        .isram_rvalid     (isram_rvalid),
        .isram_rready     (isram_rready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Drive inputs just after each rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst) begin
            isram_arready  = 1'b0;
            isram_rvalid   = 1'b0;
            redirect_valid = 1'b0;
        end else begin
            isram_arready = !ar_block;
            if (!resp_hold && rq.size() > 0) begin
                isram_rvalid = 1'b1;
                isram_rdata  = inst_of(rq[0].addr);
                isram_rresp  = (rq[0].addr == err_addr) ? 2'b10 : 2'b00;
            end else begin
                isram_rvalid = 1'b0;
                isram_rdata  = '0;
                isram_rresp  = '0;
            end
            redirect_valid   = redir_req;
            redirect_pc      = redir_target;
            redir_req        = 1'b0;
            ifu_to_idu_ready = idu_ready;
        end
    end

    // Observe the handshakes that will complete at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            if (ifu_to_idu_valid && ifu_to_idu_ready) begin
                obs_t o;
                o.pc = ifu_to_idu_pc; o.inst = ifu_to_idu_inst;
                o.fault = ifu_to_idu_fault; o.cyc = cyc;
                idu_log.push_back(o);
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL idu_unexpected: got pc=%h want none", ifu_to_idu_pc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (ifu_to_idu_pc !== e.pc || ifu_to_idu_inst !== e.inst || ifu_to_idu_fault !== e.fault) begin
                        bad++;
                        $display("FAIL idu_data: got pc=%h inst=%h f=%b want pc=%h inst=%h f=%b",
                                 ifu_to_idu_pc, ifu_to_idu_inst, ifu_to_idu_fault, e.pc, e.inst, e.fault);
                    end
                end
            end
            if (ar_wait) begin
                total++;
                if (isram_arvalid !== 1'b1 || isram_araddr !== ar_held) begin
                    bad++;
                    $display("FAIL ar_stable: got v=%b a=%h want v=1 a=%h", isram_arvalid, isram_araddr, ar_held);
                end
            end
            ar_wait = isram_arvalid && !isram_arready;
            ar_held = isram_araddr;
            if (redirect_valid) begin
                sb.delete();
                foreach (rq[i]) rq[i].stale = 1'b1;
                if (isram_arvalid && !isram_arready) pend_stale = 1'b1;
            end
            if (isram_rvalid && isram_rready && rq.size() > 0) begin
                rq_t r;
                r = rq.pop_front();
                if (!r.stale) begin
                    exp_t e;
                    e.pc    = r.addr;
                    e.fault = (r.addr == err_addr);
                    e.inst  = e.fault ? 32'h0 : inst_of(r.addr);
                    sb.push_back(e);
                end
            end
            if (isram_arvalid && isram_arready) begin
                rq_t r;
                r.addr  = isram_araddr;
                r.stale = pend_stale || redirect_valid;
                pend_stale = 1'b0;
                rq.push_back(r);
                ar_log.push_back(isram_araddr);
            end
        end
    end

    task automatic clear_model();
        rq.delete(); sb.delete(); idu_log.delete(); ar_log.delete();
        pend_stale = 1'b0; ar_wait = 1'b0; redir_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic wait_idu(input int n, input int budget, input string tag);
        int k = 0;
        while (idu_log.size() < n && k < budget) begin
            @(posedge clk); k++;
        end
        if (idu_log.size() < n) begin
            total++; bad++;
            $display("FAIL %s_timeout: got %0d words want %0d", tag, idu_log.size(), n);
        end
    endtask

    task automatic check_pc(input int idx, input logic [31:0] want, input string tag);
        logic [31:0] got;
        got = (idx < idu_log.size()) ? idu_log[idx].pc : 32'hxxxx_xxxx;
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s[%0d]: got pc=%h want %h", tag, idx, got, want);
        end
    endtask

    task automatic test_reset();
        idu_ready = 1'b1; resp_hold = 1'b0; ar_block = 1'b0; err_addr = '0;
        @(posedge clk); #2;
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        total++;
        if ({isram_arvalid, isram_rready, ifu_to_idu_valid, ifu_to_idu_fault} !== 4'b0 ||
            ifu_to_idu_pc !== 32'h0 || ifu_to_idu_inst !== 32'h0) begin
            bad++;
            $display("FAIL reset_outs: got arv=%b rr=%b v=%b pc=%h inst=%h f=%b want all 0",
                     isram_arvalid, isram_rready, ifu_to_idu_valid, ifu_to_idu_pc, ifu_to_idu_inst, ifu_to_idu_fault);
        end
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2;
        total++;
        if (isram_rready !== 1'b1 || isram_arvalid !== 1'b1 || isram_araddr !== RST_PC) begin
            bad++;
            $display("FAIL first_ar: got rr=%b arv=%b a=%h want 1 1 %h", isram_rready, isram_arvalid, isram_araddr, RST_PC);
        end
    endtask

    task automatic test_steady();
        idu_ready = 1'b1; resp_hold = 1'b0; ar_block = 1'b0;
        do_reset();
        wait_idu(10, 200, "steady");
        for (int i = 0; i < 8; i++) check_pc(i, RST_PC + 32'(4 * i), "steady_pc");
        for (int i = 5; i < 8; i++) begin
            total++;
            if (idu_log.size() <= i || idu_log[i].cyc - idu_log[i-1].cyc != 1) begin
                bad++;
                $display("FAIL steady_rate[%0d]: got gap %0d want 1", i,
                         (idu_log.size() > i) ? idu_log[i].cyc - idu_log[i-1].cyc : -1);
            end
        end
    endtask

    task automatic test_backpressure();
        idu_ready = 1'b0; resp_hold = 1'b0; ar_block = 1'b0;
        do_reset();
        repeat (20) @(posedge clk);
        #2;
        total++;
        if (ar_log.size() != 4 || isram_arvalid !== 1'b0) begin
            bad++;
            $display("FAIL bp_issue: got ars=%0d arv=%b want 4 0", ar_log.size(), isram_arvalid);
        end
        total++;
        if (ifu_to_idu_valid !== 1'b1 || ifu_to_idu_pc !== RST_PC) begin
            bad++;
            $display("FAIL bp_head: got v=%b pc=%h want 1 %h", ifu_to_idu_valid, ifu_to_idu_pc, RST_PC);
        end
        idu_ready = 1'b1;
        wait_idu(6, 100, "bp");
        for (int i = 0; i < 6; i++) check_pc(i, RST_PC + 32'(4 * i), "bp_pc");
    endtask

    task automatic test_redirect_drop();
        int stale_seen = 0;
        idu_ready = 1'b1; resp_hold = 1'b1; ar_block = 1'b0;
        do_reset();
        repeat (8) @(posedge clk);
        #2;
        total++;
        if (ar_log.size() != 2 || isram_arvalid !== 1'b0) begin
            bad++;
            $display("FAIL drop_ost: got ars=%0d arv=%b want 2 0", ar_log.size(), isram_arvalid);
        end
        redir_target = RD_PC; redir_req = 1'b1;
        repeat (2) @(posedge clk);
        #2 resp_hold = 1'b0;
        wait_idu(3, 100, "drop");
        check_pc(0, RD_PC, "drop_pc");
        check_pc(1, RD_PC + 32'd4, "drop_pc");
        total++;
        if (ar_log.size() < 3 || ar_log[2] !== RD_PC) begin
            bad++;
            $display("FAIL drop_ar: got %h want %h", (ar_log.size() > 2) ? ar_log[2] : 32'hx, RD_PC);
        end
        foreach (idu_log[i]) if (idu_log[i].pc < RD_PC) stale_seen++;
        total++;
        if (stale_seen != 0) begin
            bad++;
            $display("FAIL drop_stale: got %0d stale words want 0", stale_seen);
        end
    endtask

    task automatic test_redirect_pending();
        int k = 0;
        idu_ready = 1'b1; resp_hold = 1'b0; ar_block = 1'b1;
        do_reset();
        while (isram_arvalid !== 1'b1 && k < 20) begin @(posedge clk); #2; k++; end
        total++;
        if (isram_arvalid !== 1'b1 || isram_araddr !== RST_PC) begin
            bad++;
            $display("FAIL pend_ar: got v=%b a=%h want 1 %h", isram_arvalid, isram_araddr, RST_PC);
        end
        redir_target = RD_PC; redir_req = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        total++;
        if (isram_arvalid !== 1'b1 || isram_araddr !== RST_PC) begin
            bad++;
            $display("FAIL pend_hold: got v=%b a=%h want 1 %h", isram_arvalid, isram_araddr, RST_PC);
        end
        ar_block = 1'b0;
        wait_idu(2, 100, "pend");
        total++;
        if (ar_log.size() < 2 || ar_log[0] !== RST_PC || ar_log[1] !== RD_PC) begin
            bad++;
            $display("FAIL pend_seq: got n=%0d a1=%h want a0=%h a1=%h", ar_log.size(),
                     (ar_log.size() > 1) ? ar_log[1] : 32'hx, RST_PC, RD_PC);
        end
        check_pc(0, RD_PC, "pend_pc");
    endtask

    task automatic test_fault();
        idu_ready = 1'b1; resp_hold = 1'b0; ar_block = 1'b0;
        err_addr = RST_PC + 32'd4;
        do_reset();
        wait_idu(3, 100, "fault");
        total++;
        if (idu_log.size() < 3 || idu_log[1].pc !== err_addr || idu_log[1].inst !== 32'h0 || idu_log[1].fault !== 1'b1) begin
            bad++;
            $display("FAIL fault_word: got pc=%h inst=%h f=%b want %h 0 1",
                     (idu_log.size() > 1) ? idu_log[1].pc : 32'hx,
                     (idu_log.size() > 1) ? idu_log[1].inst : 32'hx,
                     (idu_log.size() > 1) ? idu_log[1].fault : 1'bx, err_addr);
        end
        total++;
        if (idu_log.size() < 3 || idu_log[2].pc !== RST_PC + 32'd8 || idu_log[2].fault !== 1'b0) begin
            bad++;
            $display("FAIL fault_next: got pc=%h f=%b want %h 0",
                     (idu_log.size() > 2) ? idu_log[2].pc : 32'hx,
                     (idu_log.size() > 2) ? idu_log[2].fault : 1'bx, RST_PC + 32'd8);
        end
        err_addr = '0;
    endtask

    task automatic test_async_reset();
        idu_ready = 1'b1; resp_hold = 1'b0; ar_block = 1'b0;
        do_reset();
        wait_idu(3, 100, "arst");
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        total++;
        if (isram_arvalid !== 1'b0 || ifu_to_idu_valid !== 1'b0 || isram_rready !== 1'b0) begin
            bad++;
            $display("FAIL arst_drop: got arv=%b v=%b rr=%b want 0 0 0", isram_arvalid, ifu_to_idu_valid, isram_rready);
        end
        clear_model();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        wait_idu(2, 100, "arst_restart");
        check_pc(0, RST_PC, "arst_pc");
        check_pc(1, RST_PC + 32'd4, "arst_pc");
    endtask

    initial begin
        test_reset();
        test_steady();
        test_backpressure();
        test_redirect_drop();
        test_redirect_pending();
        test_fault();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
